if_stage_fetch: RTL and testbench
=================================

Name: if_stage_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage; drives its PC_in and Instruction.
- Owns the PC and fetches through a variable-latency req/ack instruction-memory port.
- Holds on Freeze, redirects and flushes on Branch_taken, and inserts bubbles while memory is slow.
- FSM states: WAIT, BUFFERED, DRAIN.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word used for bubbles and flushes.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Freeze  input  1  hazard stall from hazard unit; hold IF/ID and PC.
- Branch_taken  input  1  redirect request from EX; flush IF/ID.
- Branch_addr  input  32  redirect target; sampled when Branch_taken=1.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction.
- PC_out  output  32  IF/ID register: fetch address + PC_STEP.
- Instruction  output  32  IF/ID register: instruction word.
- Valid_out  output  1  IF/ID register: 1 = real instruction, 0 = bubble.
- Bubble_count  output  32  saturating count of cycles IF/ID loaded a bubble for memory latency.

Behaviour:
- Reset: PC=RESET_PC, state=WAIT, PC_out=0, Instruction=NOP_INSTR, Valid_out=0, Bubble_count=0, redirect register=0.
  - imem_req=0 in the reset cycle; the first request is issued in the first cycle after rst deasserts.
- imem_req=1 in WAIT and DRAIN, 0 in BUFFERED; combinational from state.
- imem_addr=PC in WAIT, old PC in DRAIN.
- Priority per cycle: rst > Branch_taken > Freeze > normal.
- WAIT, ack=1, Freeze=0, no branch:
  - IF/ID <= {PC+PC_STEP, imem_rdata, 1}; PC <= PC+PC_STEP; stay WAIT.
  - Back-to-back: the new address is presented the next cycle, so throughput is 1 instruction/cycle with zero-latency memory.
- WAIT, ack=1, Freeze=1:
  - Capture rdata and PC into the buffer; IF/ID holds; go BUFFERED.
- WAIT, ack=0, Freeze=0:
  - IF/ID <= {0, NOP_INSTR, 0}; Bubble_count += 1, saturating at 32'hFFFF_FFFF.
- WAIT, ack=0, Freeze=1:
  - IF/ID holds; no count.
- BUFFERED, Freeze=1: hold everything.
- BUFFERED, Freeze=0:
  - IF/ID <= {buf_pc+PC_STEP, buf_instr, 1}; PC <= buf_pc+PC_STEP; go WAIT.
- Branch_taken=1 (Freeze ignored):
  - IF/ID <= {0, NOP_INSTR, 0}.
  - From BUFFERED: discard buffer; PC <= Branch_addr; go WAIT.
  - From WAIT with ack=1 the same cycle: discard rdata; PC <= Branch_addr; go WAIT.
  - From WAIT with ack=0: the request is outstanding. Store Branch_addr in the redirect register; go DRAIN.
  - From DRAIN: overwrite the redirect register with the newer Branch_addr.
- DRAIN:
  - Keep requesting the old address; on ack discard rdata, PC <= redirect register, go WAIT.
  - IF/ID loads bubbles each cycle with Valid_out=0; these are not counted in Bubble_count.
- Arithmetic: PC+PC_STEP wraps modulo 2^32 (32'hFFFF_FFFC -> 0), with no flag.
- Freeze never suppresses a flush; a flushed bubble is never replaced by held data.

Test Plan:
- Reset then zero-latency memory (ack every cycle, rdata=addr^32'hA5A5_0000):
  - first req cycle 1 addr 0; PC_out/Instruction sequence 4/A5A5_0000, 8/A5A5_0004, 12/A5A5_0008 on consecutive cycles.
- Memory latency 2 (ack every 3rd cycle):
  - Valid_out pattern 0,0,1 repeating; Bubble_count=6 after 3 instructions; imem_addr stable while awaiting ack.
- Freeze=1 for 4 cycles coinciding with ack of addr 8:
  - imem_req drops and IF/ID holds PC_out=8.
  - On Freeze release, the next cycle shows PC_out=12 with the buffered word; the next request is at addr 12.
- Branch_taken with Branch_addr=32'h100 while the request for addr 16 is unacked:
  - enter DRAIN; imem_addr stays 16 until ack; data discarded.
  - The next request is at 0x100, and the first valid PC_out is 0x104.
- Branch_taken and Freeze both high in BUFFERED:
  - IF/ID flushed (Valid_out=0, Instruction=0); next request addr = Branch_addr; buffer not delivered.
- PC=32'hFFFF_FFFC fetch completes → PC_out=0, next imem_addr=0.
- rst asserted mid-DRAIN → next cycle all outputs are at reset values and the state is WAIT.

Source files
------------

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, fetches over a
// req/ack instruction-memory port and handles freeze, branch redirect and memory bubbles.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction,
    output logic        Valid_out,
    output logic [31:0] Bubble_count
);

    typedef enum logic [1:0] {
        WAIT,
        BUFFERED,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
    logic [31:0] redirect_pc;
    logic [31:0] pc_next_seq;
    logic [31:0] buf_pc_next;

    assign pc_next_seq = pc + 32'(PC_STEP);
    assign buf_pc_next = buf_pc + 32'(PC_STEP);

    // The address never moves while a request is outstanding: in DRAIN the PC is
    // only replaced once the old fetch is acknowledged, so pc doubles as imem_addr.
    assign imem_req  = !rst && (state != BUFFERED);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT;
            pc           <= RESET_PC;
            buf_pc       <= 32'h0;
            buf_instr    <= NOP_INSTR;
            redirect_pc  <= 32'h0;
            PC_out       <= 32'h0;
            Instruction  <= NOP_INSTR;
            Valid_out    <= 1'b0;
            Bubble_count <= 32'h0;
        end else if (Branch_taken) begin
            PC_out      <= 32'h0;
            Instruction <= NOP_INSTR;
            Valid_out   <= 1'b0;
            case (state)
                BUFFERED: begin
                    pc    <= Branch_addr;
                    state <= WAIT;
                end
                WAIT, DRAIN: begin
                    // An unacked request must complete before the redirect can take over.
                    if (imem_ack) begin
                        pc    <= Branch_addr;
                        state <= WAIT;
                    end else begin
                        redirect_pc <= Branch_addr;
                        state       <= DRAIN;
                    end
                end
                default: state <= WAIT;
            endcase
        end else begin
            case (state)
                WAIT: begin
                    if (imem_ack) begin
                        if (Freeze) begin
                            buf_pc    <= pc;
                            buf_instr <= imem_rdata;
                            state     <= BUFFERED;
                        end else begin
                            PC_out      <= pc_next_seq;
                            Instruction <= imem_rdata;
                            Valid_out   <= 1'b1;
                            pc          <= pc_next_seq;
                        end
                    end else if (!Freeze) begin
                        PC_out      <= 32'h0;
                        Instruction <= NOP_INSTR;
                        Valid_out   <= 1'b0;
                        if (Bubble_count != 32'hFFFF_FFFF)
                            Bubble_count <= Bubble_count + 32'h1;
                    end
                end
                BUFFERED: begin
                    if (!Freeze) begin
                        PC_out      <= buf_pc_next;
                        Instruction <= buf_instr;
                        Valid_out   <= 1'b1;
                        pc          <= buf_pc_next;
                        state       <= WAIT;
                    end
                end
                DRAIN: begin
                    PC_out      <= 32'h0;
                    Instruction <= NOP_INSTR;
                    Valid_out   <= 1'b0;
                    if (imem_ack) begin
                        pc    <= redirect_pc;
                        state <= WAIT;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed, table-driven bench for if_stage_fetch with a combinational memory model
// whose read data is the fetch address XOR 32'hA5A5_0000.
module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        Freeze;
    logic        Branch_taken;
    logic [31:0] Branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction;
    logic        Valid_out;
    logic [31:0] Bubble_count;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pco;
        logic [31:0] exp_ins;
        logic        exp_vld;
        logic [31:0] exp_bc;
    } vec_t;

    vec_t vecs[$];

    if_stage_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .Freeze       (Freeze),
        .Branch_taken (Branch_taken),
        .Branch_addr  (Branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .PC_out       (PC_out),
        .Instruction  (Instruction),
        .Valid_out    (Valid_out),
        .Bubble_count (Bubble_count)
    );

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, actual, expected);
        end
    endtask

    function automatic void addVec(input logic r, input logic f, input logic b,
                                   input logic [31:0] ba, input logic a, input logic er,
                                   input logic [31:0] ea, input logic [31:0] ep,
                                   input logic [31:0] ei, input logic ev, input logic [31:0] eb);
        vec_t v;
        v.rst = r; v.frz = f; v.br = b; v.baddr = ba; v.ack = a;
        v.exp_req = er; v.exp_addr = ea; v.exp_pco = ep; v.exp_ins = ei;
        v.exp_vld = ev; v.exp_bc = eb;
        vecs.push_back(v);
    endfunction

    // Inputs go in just after the falling edge; request/address are checked before the
    // rising edge, the IF/ID register and bubble counter just after it.
    task automatic applyStimulus(input int idx, input vec_t v);
        rst          = v.rst;
        Freeze       = v.frz;
        Branch_taken = v.br;
        Branch_addr  = v.baddr;
        imem_ack     = v.ack;
        #1;
        checkOutput("imem_req", idx, {31'h0, imem_req}, {31'h0, v.exp_req});
        checkOutput("imem_addr", idx, imem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        checkOutput("PC_out", idx, PC_out, v.exp_pco);
        checkOutput("Instruction", idx, Instruction, v.exp_ins);
        checkOutput("Valid_out", idx, {31'h0, Valid_out}, {31'h0, v.exp_vld});
        checkOutput("Bubble_count", idx, Bubble_count, v.exp_bc);
        @(negedge clk);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b1;
        Freeze       = 1'b0;
        Branch_taken = 1'b0;
        Branch_addr  = 32'h0;
        imem_ack     = 1'b0;

        // rst frz br baddr ack | req addr pc_out instr valid bubbles
        // zero-latency memory
        addVec(0,0,0,32'h0,1, 1,32'h0,  32'h4,  32'hA5A5_0000,1,32'd0);
        addVec(0,0,0,32'h0,1, 1,32'h4,  32'h8,  32'hA5A5_0004,1,32'd0);
        addVec(0,0,0,32'h0,1, 1,32'h8,  32'hC,  32'hA5A5_0008,1,32'd0);
        // latency 2: ack every third cycle
        addVec(0,0,0,32'h0,0, 1,32'hC,  32'h0,  32'h0,        0,32'd1);
        addVec(0,0,0,32'h0,0, 1,32'hC,  32'h0,  32'h0,        0,32'd2);
        addVec(0,0,0,32'h0,1, 1,32'hC,  32'h10, 32'hA5A5_000C,1,32'd2);
        addVec(0,0,0,32'h0,0, 1,32'h10, 32'h0,  32'h0,        0,32'd3);
        addVec(0,0,0,32'h0,0, 1,32'h10, 32'h0,  32'h0,        0,32'd4);
        addVec(0,0,0,32'h0,1, 1,32'h10, 32'h14, 32'hA5A5_0010,1,32'd4);
        addVec(0,0,0,32'h0,0, 1,32'h14, 32'h0,  32'h0,        0,32'd5);
        addVec(0,0,0,32'h0,0, 1,32'h14, 32'h0,  32'h0,        0,32'd6);
        addVec(0,0,0,32'h0,1, 1,32'h14, 32'h18, 32'hA5A5_0014,1,32'd6);
        // freeze coinciding with ack of addr 0x18, held four cycles
        addVec(0,1,0,32'h0,1, 1,32'h18, 32'h18, 32'hA5A5_0014,1,32'd6);
        addVec(0,1,0,32'h0,0, 0,32'h18, 32'h18, 32'hA5A5_0014,1,32'd6);
        addVec(0,1,0,32'h0,0, 0,32'h18, 32'h18, 32'hA5A5_0014,1,32'd6);
        addVec(0,1,0,32'h0,0, 0,32'h18, 32'h18, 32'hA5A5_0014,1,32'd6);
        addVec(0,0,0,32'h0,0, 0,32'h18, 32'h1C, 32'hA5A5_0018,1,32'd6);
        addVec(0,0,0,32'h0,1, 1,32'h1C, 32'h20, 32'hA5A5_001C,1,32'd6);
        // branch to 0x100 while addr 0x20 is unacked: drain then redirect
        addVec(0,0,1,32'h100,0, 1,32'h20, 32'h0, 32'h0,       0,32'd6);
        addVec(0,0,0,32'h0,0,   1,32'h20, 32'h0, 32'h0,       0,32'd6);
        addVec(0,0,0,32'h0,1,   1,32'h20, 32'h0, 32'h0,       0,32'd6);
        addVec(0,0,0,32'h0,1,   1,32'h100,32'h104,32'hA5A5_0100,1,32'd6);
        // branch and freeze together while buffered
        addVec(0,1,0,32'h0,1,   1,32'h104,32'h104,32'hA5A5_0100,1,32'd6);
        addVec(0,1,1,32'h200,0, 0,32'h104,32'h0,  32'h0,        0,32'd6);
        addVec(0,0,0,32'h0,1,   1,32'h200,32'h204,32'hA5A5_0200,1,32'd6);
        // freeze with no ack in WAIT: hold, no count
        addVec(0,1,0,32'h0,0,   1,32'h204,32'h204,32'hA5A5_0200,1,32'd6);
        // branch with ack same cycle, then PC wrap at 0xFFFF_FFFC
        addVec(0,0,1,32'hFFFF_FFFC,1, 1,32'h204,     32'h0,32'h0,        0,32'd6);
        addVec(0,0,0,32'h0,1,         1,32'hFFFF_FFFC,32'h0,32'h5A5A_FFFC,1,32'd6);
        addVec(0,0,0,32'h0,1,         1,32'h0,       32'h4,32'hA5A5_0000,1,32'd6);
        // second branch while draining overrides the first
        addVec(0,0,1,32'h300,0, 1,32'h4,  32'h0, 32'h0, 0,32'd6);
        addVec(0,0,1,32'h400,0, 1,32'h4,  32'h0, 32'h0, 0,32'd6);
        addVec(0,0,0,32'h0,1,   1,32'h4,  32'h0, 32'h0, 0,32'd6);
        addVec(0,0,0,32'h0,0,   1,32'h400,32'h0, 32'h0, 0,32'd7);
        // reset in the middle of a drain
        addVec(0,0,1,32'h500,0, 1,32'h400,32'h0, 32'h0, 0,32'd7);
        addVec(1,0,0,32'h0,0,   0,32'h400,32'h0, 32'h0, 0,32'd0);
        addVec(0,0,0,32'h0,0,   1,32'h0,  32'h0, 32'h0, 0,32'd1);

        // reset cycle: no request while rst is high, all registers at reset values
        @(negedge clk);
        #1;
        checkOutput("reset_req", -1, {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_PC_out", -1, PC_out, 32'h0);
        checkOutput("reset_Instruction", -1, Instruction, 32'h0);
        checkOutput("reset_Valid_out", -1, {31'h0, Valid_out}, 32'h0);
        checkOutput("reset_Bubble_count", -1, Bubble_count, 32'h0);
        @(negedge clk);

        foreach (vecs[i]) applyStimulus(i, vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
